// File: rtl/smpl_pkg.sv
// Shared definitions for the sample-clock / strobe generator.
// Holds the reset divide ratio, the minimum legal divide ratio, the
// divide-field type, the run/idle state type and the helper that gives the
// length of the smpl_clk high phase.
package smpl_pkg;

    localparam int DIV_W_DEF = 8;
    localparam int DIV_DEF   = 50;  // 50 MHz system clock -> 1 MHz sample clock
    localparam int DIV_MIN   = 2;   // smallest ratio that still gives a real clock

    typedef logic [DIV_W_DEF-1:0] div_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Number of cycles smpl_clk stays high in one period.
    // Odd ratios give the extra cycle to the high phase (5 -> 3 high, 2 low).
    function automatic int unsigned hi_len(input int unsigned div);
        return div - (div >> 1);
    endfunction

endpackage

// File: rtl/smpl_strb_ch.sv
// One strobe channel of the sample-clock generator.
// Emits a one-clock strobe when the shared phase counter equals this
// channel's active phase, and keeps a sticky flag recording that the
// last applied phase lies outside the active period.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   en             generator running; strobes are suppressed when low
//   cnt            current phase counter from the top level
//   phase          active phase of this channel
//   apply          new configuration is being applied this cycle
//   new_phase      phase being applied
//   new_div        divide ratio being applied
//   st             registered strobe
//   cfg_err        sticky: applied phase >= applied divide ratio
module smpl_strb_ch #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] cnt,
    input  logic [DIV_W-1:0] phase,
    input  logic             apply,
    input  logic [DIV_W-1:0] new_phase,
    input  logic [DIV_W-1:0] new_div,
    output logic             st,
    output logic             cfg_err
);

    logic st_q, st_d;
    logic cfg_err_q, cfg_err_d;

    always_comb begin
        st_d      = en && (cnt == phase);
        cfg_err_d = cfg_err_q;
        // The flag only changes when a configuration is applied, so it
        // both sets on a bad phase and clears on a good one here.
        if (apply) begin
            cfg_err_d = (new_phase >= new_div);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q      <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign st      = st_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: rtl/smpl_strb_gen.sv
// Programmable sample-clock and multi-channel strobe generator.
// Divides clk by a run-time ratio into a 50%-duty smpl_clk and N_CH
// independently phased one-clock strobes. New ratio/phases are staged in
// pending registers and applied only at a period boundary (or while idle),
// so the period in progress always completes unchanged.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   en           run enable; low holds the generator idle
//   div_ld       one-cycle request to stage div_val / phase_val
//   div_val      new divide ratio (values below 2 are clamped to 2)
//   phase_val    per-channel phases, channel k at [k*DIV_W +: DIV_W]
//   smpl_clk     divided sample clock (registered)
//   st           per-channel one-clock strobes
//   smpl_cnt     completed sample periods, wrapping
//   cfg_err      per-channel sticky "phase out of range" flags
module smpl_strb_gen
    import smpl_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DIV_DEF = smpl_pkg::DIV_DEF,
    parameter int N_CH    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  div_ld,
    input  logic [DIV_W-1:0]      div_val,
    input  logic [N_CH*DIV_W-1:0] phase_val,
    output logic                  smpl_clk,
    output logic [N_CH-1:0]       st,
    output logic [CNT_W-1:0]      smpl_cnt,
    output logic [N_CH-1:0]       cfg_err
);

    state_e                state_q, state_d;
    logic [DIV_W-1:0]      cnt_q, cnt_d;
    logic [DIV_W-1:0]      div_act_q, div_act_d;
    logic [N_CH*DIV_W-1:0] phase_act_q, phase_act_d;
    logic                  pend_q, pend_d;
    logic [DIV_W-1:0]      pend_div_q, pend_div_d;
    logic [N_CH*DIV_W-1:0] pend_phase_q, pend_phase_d;
    logic                  smpl_clk_q, smpl_clk_d;
    logic [CNT_W-1:0]      smpl_cnt_q, smpl_cnt_d;
    logic                  wrap;
    logic                  apply;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_act_d    = div_act_q;
        phase_act_d  = phase_act_q;
        pend_d       = pend_q;
        pend_div_d   = pend_div_q;
        pend_phase_d = pend_phase_q;
        smpl_cnt_d   = smpl_cnt_q;
        wrap         = 1'b0;
        apply        = 1'b0;

        case (state_q)
            ST_IDLE: if (en)  state_d = ST_RUN;
            ST_RUN:  if (!en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        wrap  = en && (cnt_q == div_act_q - DIV_W'(1));
        // While idle there is no period to protect, so staged values go live at once.
        apply = pend_q && (wrap || !en);

        if (!en || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        smpl_clk_d = en && (32'(cnt_q) < hi_len(32'(div_act_q)));

        if (wrap) begin
            smpl_cnt_d = smpl_cnt_q + CNT_W'(1);
        end

        if (apply) begin
            div_act_d   = pend_div_q;
            phase_act_d = pend_phase_q;
            pend_d      = 1'b0;
        end

        // A load in the same cycle as an apply is kept for the next boundary.
        if (div_ld) begin
            pend_d       = 1'b1;
            pend_div_d   = (div_val < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div_val;
            pend_phase_d = phase_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            div_act_q    <= DIV_W'(DIV_DEF);
            for (int k = 0; k < N_CH; k++) begin
                phase_act_q[k*DIV_W +: DIV_W] <= DIV_W'(k);
            end
            pend_q       <= 1'b0;
            pend_div_q   <= '0;
            pend_phase_q <= '0;
            smpl_clk_q   <= 1'b0;
            smpl_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_act_q    <= div_act_d;
            phase_act_q  <= phase_act_d;
            pend_q       <= pend_d;
            pend_div_q   <= pend_div_d;
            pend_phase_q <= pend_phase_d;
            smpl_clk_q   <= smpl_clk_d;
            smpl_cnt_q   <= smpl_cnt_d;
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            smpl_strb_ch #(
                .DIV_W (DIV_W)
            ) u_ch (
                .clk       (clk),
                .reset     (reset),
                .en        (en),
                .cnt       (cnt_q),
                .phase     (phase_act_q[gi*DIV_W +: DIV_W]),
                .apply     (apply),
                .new_phase (pend_phase_q[gi*DIV_W +: DIV_W]),
                .new_div   (pend_div_q),
                .st        (st[gi]),
                .cfg_err   (cfg_err[gi])
            );
        end
    endgenerate

    assign smpl_clk = smpl_clk_q;
    assign smpl_cnt = smpl_cnt_q;

endmodule

// File: tb/tb_smpl_strb_gen.sv
module tb_smpl_strb_gen;

    localparam int DIV_W = 8;
    localparam int N_CH  = 2;
    localparam int CNT_W = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  en;
    logic                  div_ld;
    logic [DIV_W-1:0]      div_val;
    logic [N_CH*DIV_W-1:0] phase_val;
    logic                  smpl_clk;
    logic [N_CH-1:0]       st;
    logic [CNT_W-1:0]      smpl_cnt;
    logic [N_CH-1:0]       cfg_err;

    always #5 clk = ~clk;

    smpl_strb_gen #(
        .DIV_W   (DIV_W),
        .DIV_DEF (50),
        .N_CH    (N_CH),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .div_ld    (div_ld),
        .div_val   (div_val),
        .phase_val (phase_val),
        .smpl_clk  (smpl_clk),
        .st        (st),
        .smpl_cnt  (smpl_cnt),
        .cfg_err   (cfg_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: position within the current sample period, the
    // live and staged configuration, and the completed-period count.
    int m_pos, m_div, m_per, m_pend, m_pdiv;
    int m_ph[N_CH];
    int m_pph[N_CH];
    int m_err[N_CH];

    logic             e_clk;
    logic [N_CH-1:0]  e_st;
    logic [N_CH-1:0]  e_err;
    logic [CNT_W-1:0] e_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos  = 0;
        m_div  = 50;
        m_per  = 0;
        m_pend = 0;
        m_pdiv = 0;
        for (int k = 0; k < N_CH; k++) begin
            m_ph[k]  = k;
            m_pph[k] = 0;
            m_err[k] = 0;
        end
    endtask

    // Advance one clock: predict from the inputs now applied, clock, compare.
    task automatic step();
        bit wrap;
        if (reset) begin
            model_reset();
            e_clk = 1'b0;
            e_st  = '0;
        end else begin
            wrap  = en && (m_pos == m_div - 1);
            e_clk = en && (m_pos < (m_div + 1) / 2);
            for (int k = 0; k < N_CH; k++) e_st[k] = en && (m_pos == m_ph[k]);
            if (wrap) m_per = (m_per + 1) % 65536;
            if (m_pend != 0 && (wrap || !en)) begin
                m_div = m_pdiv;
                for (int k = 0; k < N_CH; k++) begin
                    m_ph[k]  = m_pph[k];
                    m_err[k] = (m_pph[k] >= m_pdiv) ? 1 : 0;
                end
                m_pend = 0;
            end
            if (div_ld) begin
                m_pend = 1;
                m_pdiv = (int'(div_val) < 2) ? 2 : int'(div_val);
                for (int k = 0; k < N_CH; k++) m_pph[k] = int'(phase_val[k*DIV_W +: DIV_W]);
            end
            m_pos = !en ? 0 : (wrap ? 0 : m_pos + 1);
        end
        e_cnt = CNT_W'(m_per);
        for (int k = 0; k < N_CH; k++) e_err[k] = (m_err[k] != 0);

        @(posedge clk);
        #1;
        chk("smpl_clk", 32'(smpl_clk), 32'(e_clk));
        chk("st",       32'(st),       32'(e_st));
        chk("smpl_cnt", 32'(smpl_cnt), 32'(e_cnt));
        chk("cfg_err",  32'(cfg_err),  32'(e_err));
        div_ld = 1'b0;
        reset  = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input int d, input int p1, input int p0);
        div_ld    = 1'b1;
        div_val   = DIV_W'(d);
        phase_val = {DIV_W'(p1), DIV_W'(p0)};
    endtask

    // Step until the model says the coming cycle is at position p.
    task automatic run_to(input int p);
        int guard = 0;
        while (m_pos != p && guard < 600) begin
            step();
            guard++;
        end
        if (m_pos != p) begin
            errors++;
            $display("FAIL run_to position %0d reached %0d", p, m_pos);
        end
    endtask

    initial begin
        reset     = 1'b1;
        en        = 1'b0;
        div_ld    = 1'b0;
        div_val   = '0;
        phase_val = '0;
        model_reset();

        // Reset state, with en and div_ld also asserted to show reset wins
        en = 1'b1;
        load(7, 3, 3);
        reset = 1'b1;
        step();
        en = 1'b0;
        reset = 1'b1;
        step();
        $display("reset: smpl_clk=%b st=%b smpl_cnt=%0d cfg_err=%b", smpl_clk, st, smpl_cnt, cfg_err);

        // Default 50-clk period with strobes at phase 0 and 1
        en = 1'b1;
        run(250);
        $display("default run: smpl_cnt=%0d", smpl_cnt);

        // Ratio 5 loaded mid-period; current period completes first
        run_to(17);
        load(5, 3, 0);
        run(80);
        $display("div 5: smpl_cnt=%0d", smpl_cnt);

        // Load during the wrap cycle: applied one period later
        run_to(4);
        load(9, 8, 2);
        run(40);
        $display("wrap-cycle load: smpl_cnt=%0d", smpl_cnt);

        // Clamped ratios
        load(1, 1, 0);
        run(20);
        load(0, 0, 1);
        run(20);
        $display("clamped: smpl_cnt=%0d", smpl_cnt);

        // Two loads before the boundary: last one wins
        load(12, 4, 4);
        step();
        load(50, 60, 0);
        run(130);
        $display("bad phase: cfg_err=%b", cfg_err);
        load(50, 10, 0);
        run(110);
        $display("good phase: cfg_err=%b", cfg_err);

        // Idle gap at cnt 20 with a load staged while idle
        run_to(20);
        en = 1'b0;
        run(3);
        load(40, 5, 0);
        run(4);
        en = 1'b1;
        run(120);
        $display("idle gap: smpl_cnt=%0d", smpl_cnt);

        // Reset mid-period with a pending load
        run_to(15);
        load(6, 2, 1);
        step();
        reset = 1'b1;
        step();
        run(120);
        $display("reset mid-period: smpl_cnt=%0d", smpl_cnt);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            en    = ($urandom_range(0, 19) != 0);
            reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 24) == 0) begin
                if ($urandom_range(0, 7) == 0)
                    load($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
                else
                    load($urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(0, 14));
            end
            step();
        end
        $display("random: smpl_cnt=%0d cfg_err=%b", smpl_cnt, cfg_err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
